// File: rtl/mem_access_pkg.sv
// Shared types, op codes and lane helpers for the mem_access stage.
package mem_access_pkg;

   typedef logic [31:0] reg_t;
   typedef logic [4:0]  reg_addr_t;
   typedef logic [7:0]  alu_op_t;

   localparam logic RST_ENABLE = 1'b1;
   localparam reg_t ZERO_WORD  = 32'h0000_0000;

   localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
   localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
   localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
   localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
   localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
   localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
   localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
   localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   function automatic logic is_mem_op(input alu_op_t op);
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   function automatic logic is_store_op(input alu_op_t op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
   endfunction

   // Big-endian lanes: address 0 owns the most significant byte.
   function automatic logic [3:0] lane_sel(input alu_op_t op, input logic [1:0] a);
      case (op)
         EXE_LW_OP, EXE_SW_OP:             return 4'b1111;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[1] ? 4'b0011 : 4'b1100;
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
            case (a)
               2'b00:   return 4'b1000;
               2'b01:   return 4'b0100;
               2'b10:   return 4'b0010;
               default: return 4'b0001;
            endcase
         end
         default:                          return 4'b0000;
      endcase
   endfunction

   function automatic reg_t store_data(input alu_op_t op, input reg_t reg2);
      case (op)
         EXE_SB_OP: return {4{reg2[7:0]}};
         EXE_SH_OP: return {2{reg2[15:0]}};
         default:   return reg2;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction and sign/zero extension for the mem_access stage.
module mem_load_align
   import mem_access_pkg::*;
(
   input  alu_op_t     aluop,
   input  logic [1:0]  addr,
   input  reg_t        rdata,
   output reg_t        data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (addr)
         2'b00:   byte_lane = rdata[31:24];
         2'b01:   byte_lane = rdata[23:16];
         2'b10:   byte_lane = rdata[15:8];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr[1] ? rdata[15:0] : rdata[31:16];
      case (aluop)
         EXE_LB_OP:  data = {{24{byte_lane[7]}}, byte_lane};
         EXE_LBU_OP: data = {24'h000000, byte_lane};
         EXE_LH_OP:  data = {{16{half_lane[15]}}, half_lane};
         EXE_LHU_OP: data = {16'h0000, half_lane};
         EXE_LW_OP:  data = rdata;
         default:    data = ZERO_WORD;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: load/store bus handshake with pipeline stall.
// Optional bus timeout (bus_err port, TIMEOUT_CYCLES) with MEM_BUS_TIMEOUT_EN.
//
// state    | meaning
// MEM_IDLE | pass-through; a memory op stalls and launches the request
// MEM_REQ  | request on the bus, stalled, waiting for dbus_ack
// MEM_DONE | access complete, release stall, present load data for one cycle
module mem_access
   import mem_access_pkg::*;
`ifdef MEM_BUS_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  in_waddr,
   input  logic        in_wen,
   input  logic [31:0] in_wdata,
   input  logic        in_hilo_wen,
   input  logic [31:0] in_hi,
   input  logic [31:0] in_lo,
   input  logic [7:0]  in_aluop,
   input  logic [31:0] in_mem_addr,
   input  logic [31:0] in_reg2,
   output logic [4:0]  wb_waddr,
   output logic        wb_wen,
   output logic [31:0] wb_wdata,
   output logic        wb_hilo_wen,
   output logic [31:0] wb_hi,
   output logic [31:0] wb_lo,
   output logic        mem_stall,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_sel,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack
`ifdef MEM_BUS_TIMEOUT_EN
   ,
   output logic        bus_err
`endif
);

   mem_state_t state, state_nxt, cur_state;
   logic       is_mem, is_store, is_load;
   reg_t       aligned, load_data;

   assign is_mem    = is_mem_op(in_aluop);
   assign is_store  = is_store_op(in_aluop);
   assign is_load   = is_mem & ~is_store;
   // Outputs behave as IDLE during reset even if the register has not cleared yet.
   assign cur_state = (rst == RST_ENABLE) ? MEM_IDLE : state;

`ifdef MEM_BUS_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   logic       timed_out;
   logic       timeout_hit;

   assign timeout_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
   assign bus_err     = (cur_state == MEM_DONE) && timed_out;
`endif

   mem_load_align u_align (
      .aluop (in_aluop),
      .addr  (in_mem_addr[1:0]),
      .rdata (dbus_rdata),
      .data  (aligned)
   );

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) state <= MEM_IDLE;
      else                   state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MEM_IDLE: if (is_mem) state_nxt = MEM_REQ;
         MEM_REQ: begin
            if (dbus_ack)         state_nxt = MEM_DONE;
`ifdef MEM_BUS_TIMEOUT_EN
            else if (timeout_hit) state_nxt = MEM_DONE;
`endif
         end
         MEM_DONE: state_nxt = MEM_IDLE;
         default:  state_nxt = MEM_IDLE;
      endcase
   end

   always_comb begin
      wb_waddr    = in_waddr;
      wb_wen      = in_wen;
      wb_wdata    = in_wdata;
      wb_hilo_wen = in_hilo_wen;
      wb_hi       = in_hi;
      wb_lo       = in_lo;
      mem_stall   = 1'b0;
      case (cur_state)
         MEM_IDLE: mem_stall = is_mem;
         MEM_REQ:  mem_stall = 1'b1;
         MEM_DONE: begin
            if (is_load) wb_wdata = load_data;
`ifdef MEM_BUS_TIMEOUT_EN
            if (timed_out) wb_wen = 1'b0;
`endif
         end
         default: ;
      endcase
      if (mem_stall) begin
         wb_wen      = 1'b0;
         wb_hilo_wen = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= ZERO_WORD;
         dbus_sel   <= 4'b0000;
         dbus_wdata <= ZERO_WORD;
         load_data  <= ZERO_WORD;
`ifdef MEM_BUS_TIMEOUT_EN
         tmo_cnt    <= 8'd0;
         timed_out  <= 1'b0;
`endif
      end else begin
         case (state)
            MEM_IDLE: begin
               if (is_mem) begin
                  dbus_req   <= 1'b1;
                  dbus_we    <= is_store;
                  dbus_addr  <= {in_mem_addr[31:2], 2'b00};
                  dbus_sel   <= lane_sel(in_aluop, in_mem_addr[1:0]);
                  dbus_wdata <= store_data(in_aluop, in_reg2);
`ifdef MEM_BUS_TIMEOUT_EN
                  tmo_cnt    <= 8'd0;
`endif
               end
            end
            MEM_REQ: begin
               if (dbus_ack) begin
                  dbus_req  <= 1'b0;
                  dbus_we   <= 1'b0;
                  load_data <= aligned;
`ifdef MEM_BUS_TIMEOUT_EN
               end else if (timeout_hit) begin
                  dbus_req  <= 1'b0;
                  dbus_we   <= 1'b0;
                  load_data <= ZERO_WORD;
                  timed_out <= 1'b1;
`endif
               end
`ifdef MEM_BUS_TIMEOUT_EN
               tmo_cnt <= tmo_cnt + 8'd1;
`endif
            end
            default: begin
`ifdef MEM_BUS_TIMEOUT_EN
               timed_out <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed table, reset/timeout sequences, random ops.
module tb_mem_access;

   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_LBU = 8'b1110_0100;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] OP_ADD = 8'b0010_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  in_waddr;
   logic        in_wen;
   logic [31:0] in_wdata;
   logic        in_hilo_wen;
   logic [31:0] in_hi, in_lo;
   logic [7:0]  in_aluop;
   logic [31:0] in_mem_addr, in_reg2;
   logic [4:0]  wb_waddr;
   logic        wb_wen;
   logic [31:0] wb_wdata;
   logic        wb_hilo_wen;
   logic [31:0] wb_hi, wb_lo;
   logic        mem_stall, dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_sel;
   logic        dbus_ack;
`ifdef MEM_BUS_TIMEOUT_EN
   logic        bus_err;
`endif

   int n_vec = 0;
   int n_bad = 0;

   mem_access dut (
      .clk(clk), .rst(rst),
      .in_waddr(in_waddr), .in_wen(in_wen), .in_wdata(in_wdata),
      .in_hilo_wen(in_hilo_wen), .in_hi(in_hi), .in_lo(in_lo),
      .in_aluop(in_aluop), .in_mem_addr(in_mem_addr), .in_reg2(in_reg2),
      .wb_waddr(wb_waddr), .wb_wen(wb_wen), .wb_wdata(wb_wdata),
      .wb_hilo_wen(wb_hilo_wen), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .mem_stall(mem_stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
      .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
`ifdef MEM_BUS_TIMEOUT_EN
      , .bus_err(bus_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model: byte lane n (0 = MSB) of a word, plain arithmetic.
   function automatic logic [31:0] load_model(input logic [7:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      int unsigned b, h;
      b = (rdata >> (8 * (3 - int'(addr[1:0])))) & 32'hFF;
      h = (rdata >> (16 * (1 - int'(addr[1])))) & 32'hFFFF;
      case (op)
         OP_LB:   return (b >= 128) ? b - 256 : b;
         OP_LBU:  return b;
         OP_LH:   return (h >= 32768) ? h - 65536 : h;
         OP_LHU:  return h;
         default: return rdata;
      endcase
   endfunction

   function automatic logic [3:0] sel_model(input logic [7:0] op, input logic [31:0] addr);
      if (op == OP_LW || op == OP_SW) return 4'hF;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return addr[1] ? 4'h3 : 4'hC;
      return 4'(8 >> addr[1:0]);
   endfunction

   function automatic logic [31:0] store_model(input logic [7:0] op, input logic [31:0] reg2);
      if (op == OP_SB) return (reg2 & 32'hFF) * 32'h0101_0101;
      if (op == OP_SH) return (reg2 & 32'hFFFF) * 32'h0001_0001;
      return reg2;
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return op == OP_SB || op == OP_SH || op == OP_SW;
   endfunction

   // Entered just after a rising edge in an IDLE cycle (cycle 0); ack in cycle k.
   task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int k, input logic wen,
                          input logic [31:0] wdata_in, input logic [3:0] exp_sel,
                          input logic [31:0] exp_bus_wdata, input logic [31:0] exp_wb);
      in_aluop = op; in_mem_addr = addr; in_reg2 = reg2; in_wen = wen; in_wdata = wdata_in;
      in_waddr = 5'd7; in_hilo_wen = 1'b1; in_hi = 32'h1111_2222; in_lo = 32'h3333_4444;
      @(negedge clk);
      check("c0_stall", 32'(mem_stall), 32'd1);
      check("c0_wb_wen", 32'(wb_wen), 32'd0);
      check("c0_hilo_wen", 32'(wb_hilo_wen), 32'd0);
      for (int c = 1; c <= k; c++) begin
         next_cycle();
         dbus_ack   = (c == k);
         dbus_rdata = (c == k) ? rdata : $urandom;
         @(negedge clk);
         check("req_high", 32'(dbus_req), 32'd1);
         check("req_stall", 32'(mem_stall), 32'd1);
         if (c == 1) begin
            check("bus_addr", dbus_addr, addr & 32'hFFFF_FFFC);
            check("bus_sel", 32'(dbus_sel), 32'(exp_sel));
            check("bus_we", 32'(dbus_we), 32'(is_store(op)));
            if (is_store(op)) check("bus_wdata", dbus_wdata, exp_bus_wdata);
         end
      end
      next_cycle();
      dbus_ack = 1'b0; dbus_rdata = $urandom;
      @(negedge clk);
      check("done_stall", 32'(mem_stall), 32'd0);
      check("done_req", 32'(dbus_req), 32'd0);
      check("done_wdata", wb_wdata, exp_wb);
      check("done_wen", 32'(wb_wen), 32'(wen));
      check("done_hilo_wen", 32'(wb_hilo_wen), 32'd1);
`ifdef MEM_BUS_TIMEOUT_EN
      check("done_bus_err", 32'(bus_err), 32'd0);
`endif
      next_cycle();
   endtask

   task automatic nonmem(input logic [7:0] op, input logic [4:0] wa, input logic wen,
                         input logic [31:0] wd);
      in_aluop = op; in_waddr = wa; in_wen = wen; in_wdata = wd;
      in_hilo_wen = wd[0]; in_hi = ~wd; in_lo = wd ^ 32'h0F0F_0F0F;
      in_mem_addr = $urandom; in_reg2 = $urandom;
      @(negedge clk);
      check("nm_waddr", 32'(wb_waddr), 32'(wa));
      check("nm_wen", 32'(wb_wen), 32'(wen));
      check("nm_wdata", wb_wdata, wd);
      check("nm_hilo", {wb_hi ^ ~wd, wb_lo ^ wd ^ 32'h0F0F_0F0F}, 64'd0);
      check("nm_hilo_wen", 32'(wb_hilo_wen), 32'(wd[0]));
      check("nm_stall", 32'(mem_stall), 32'd0);
      check("nm_req", 32'(dbus_req), 32'd0);
      next_cycle();
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] reg2;
      logic [31:0] rdata;
      int          k;
      logic [3:0]  sel;
      logic [31:0] bus_wdata;
      logic [31:0] wb;
   } vec_t;

   vec_t vecs[9];
   logic [7:0] ops[9];

   initial begin
      vecs[0] = '{OP_LW,  32'h100, 32'h0123_4567, 32'hDEAD_BEEF, 3, 4'b1111, 32'h0, 32'hDEAD_BEEF};
      vecs[1] = '{OP_LB,  32'h101, 32'h0,         32'h11F2_3344, 1, 4'b0100, 32'h0, 32'hFFFF_FFF2};
      vecs[2] = '{OP_LBU, 32'h101, 32'h0,         32'h11F2_3344, 2, 4'b0100, 32'h0, 32'h0000_00F2};
      vecs[3] = '{OP_LH,  32'h102, 32'h0,         32'h11F2_8344, 1, 4'b0011, 32'h0, 32'hFFFF_8344};
      vecs[4] = '{OP_LHU, 32'h100, 32'h0,         32'h8001_7FFF, 2, 4'b1100, 32'h0, 32'h0000_8001};
      vecs[5] = '{OP_LB,  32'h103, 32'h0,         32'h0000_007F, 1, 4'b0001, 32'h0, 32'h0000_007F};
      vecs[6] = '{OP_SH,  32'h202, 32'h0000_ABCD, 32'h0,         1, 4'b0011, 32'hABCD_ABCD, 32'h5555_0000};
      vecs[7] = '{OP_SB,  32'h300, 32'h1234_5678, 32'h0,         2, 4'b1000, 32'h7878_7878, 32'h5555_0000};
      vecs[8] = '{OP_SW,  32'h407, 32'hCAFE_F00D, 32'h0,         1, 4'b1111, 32'hCAFE_F00D, 32'h5555_0000};
      ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD};

      rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
      in_aluop = OP_ADD; in_waddr = 5'd0; in_wen = 1'b0; in_wdata = 32'h0;
      in_hilo_wen = 1'b0; in_hi = 32'h0; in_lo = 32'h0; in_mem_addr = 32'h0; in_reg2 = 32'h0;
      repeat (2) next_cycle();
      @(negedge clk);
      check("rst_req", 32'(dbus_req), 32'd0);
      check("rst_we", 32'(dbus_we), 32'd0);
      check("rst_addr", dbus_addr, 32'd0);
      check("rst_sel", 32'(dbus_sel), 32'd0);
      check("rst_wdata", dbus_wdata, 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      next_cycle();
      rst = 1'b0;

      nonmem(OP_ADD, 5'd5, 1'b1, 32'h0000_1234);

      // Directed table, issued back to back.
      for (int i = 0; i < 9; i++)
         mem_txn(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].rdata, vecs[i].k,
                 !is_store(vecs[i].op), 32'h5555_0000, vecs[i].sel, vecs[i].bus_wdata,
                 vecs[i].wb);

      // Ack while idle is ignored.
      dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
      nonmem(OP_ADD, 5'd9, 1'b1, 32'hA5A5_0001);
      dbus_ack = 1'b0;

      // Reset asserted in the second REQ cycle.
      in_aluop = OP_LW; in_mem_addr = 32'h500; in_wen = 1'b1; in_wdata = 32'h0000_0BAD;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; in_aluop = OP_ADD; in_wdata = 32'h0000_0600;
      @(negedge clk);
      check("rstreq_req", 32'(dbus_req), 32'd0);
      check("rstreq_stall", 32'(mem_stall), 32'd0);
      next_cycle();
      dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678;
      @(negedge clk);
      check("late_ack_wdata", wb_wdata, 32'h0000_0600);
      check("late_ack_stall", 32'(mem_stall), 32'd0);
      next_cycle();
      dbus_ack = 1'b0;
      @(negedge clk);
      check("late_ack_req", 32'(dbus_req), 32'd0);
      check("late_ack_wdata2", wb_wdata, 32'h0000_0600);
      next_cycle();

`ifdef MEM_BUS_TIMEOUT_EN
      // LW that never gets an ack (default TIMEOUT_CYCLES = 16).
      in_aluop = OP_LW; in_mem_addr = 32'h700; in_wen = 1'b1; in_wdata = 32'h0000_0777;
      for (int c = 1; c <= 16; c++) begin
         next_cycle();
         @(negedge clk);
         check($sformatf("tmo_req_c%0d", c), 32'(dbus_req), 32'd1);
      end
      next_cycle();
      @(negedge clk);
      check("tmo_bus_err", 32'(bus_err), 32'd1);
      check("tmo_stall", 32'(mem_stall), 32'd0);
      check("tmo_wen", 32'(wb_wen), 32'd0);
      check("tmo_wdata", wb_wdata, 32'd0);
      check("tmo_req", 32'(dbus_req), 32'd0);
      next_cycle();
      in_aluop = OP_ADD;
      @(negedge clk);
      check("tmo_err_clear", 32'(bus_err), 32'd0);
      next_cycle();
`endif

      // Random mix against the reference model.
      for (int i = 0; i < 60; i++) begin
         logic [7:0]  op;
         logic [31:0] addr, reg2, rdata, wd;
         logic        wen;
         op = ops[$urandom_range(0, 8)];
         addr = $urandom; reg2 = $urandom; rdata = $urandom; wd = $urandom;
         wen = 1'($urandom_range(0, 1));
         if (op == OP_ADD)
            nonmem(op, 5'($urandom), wen, wd);
         else
            mem_txn(op, addr, reg2, rdata, $urandom_range(1, 4), wen, wd,
                    sel_model(op, addr), store_model(op, reg2),
                    is_store(op) ? wd : load_model(op, addr, rdata));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
